// File: rtl/irq_vector_ctrl_if.sv
// Bundles the request, core handshake and acknowledge signals of the interrupt vector controller.
// The master side is the controller; the slave side is the core/peripheral environment.
interface irq_vector_ctrl_if #(
    parameter int NUM_IRQ = 44
);
    logic [NUM_IRQ-1:0] irq_in;
    logic               sreg_i;
    logic               instr_boundary;
    logic               reti_exec;
    logic               ivsel;
    logic               int_taken;
    logic               int_req;
    logic [15:0]        int_vec_pc;
    logic               irqack;
    logic [5:0]         irqack_addr;
    logic               clr_i;
    logic               busy;

    modport master (
        input  irq_in, sreg_i, instr_boundary, reti_exec, ivsel, int_taken,
        output int_req, int_vec_pc, irqack, irqack_addr, clr_i, busy
    );

    modport slave (
        output irq_in, sreg_i, instr_boundary, reti_exec, ivsel, int_taken,
        input  int_req, int_vec_pc, irqack, irqack_addr, clr_i, busy
    );
endinterface

// File: rtl/irq_vector_ctrl.sv
// Interrupt arbiter: picks the lowest pending vector at an instruction boundary, hands it to the
// core, acknowledges the peripheral and stays busy while the core pushes the PC and jumps.
module irq_vector_ctrl #(
    parameter int          NUM_IRQ     = 44,
    parameter logic [15:0] BOOT_BASE   = 16'h3C00,
    parameter int          CALL_CYCLES = 3
) (
    input logic               cp2,
    input logic               ireset,
    irq_vector_ctrl_if.master bus
);
    localparam int CNT_W = (CALL_CYCLES > 0) ? $clog2(CALL_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, REQ, ACK, CALL} state_t;

    state_t           state_q, state_d;
    logic [5:0]       vec_q, vec_d;
    logic             ivselLatched_q, ivselLatched_d;
    logic             guard_q, guard_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [5:0]       lowestVec;
    logic             selectedLine;
    logic             grant;

    // Lowest index wins, so scan from the top and let lower set bits overwrite.
    always_comb begin
        lowestVec = 6'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (bus.irq_in[i]) lowestVec = 6'(i + 1);
        end
    end

    always_comb begin
        selectedLine = 1'b0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (vec_q == 6'(i + 1)) selectedLine = bus.irq_in[i];
        end
    end

    // A RETI in the same cycle as a boundary blocks the grant so one instruction runs first.
    assign grant = bus.sreg_i && bus.instr_boundary && !guard_q && !bus.reti_exec
                   && (|bus.irq_in);

    always_comb begin
        state_d        = state_q;
        vec_d          = vec_q;
        ivselLatched_d = ivselLatched_q;
        guard_d        = guard_q;
        count_d        = count_q;

        if (bus.reti_exec) begin
            guard_d = 1'b1;
        end else if (bus.instr_boundary && guard_q) begin
            guard_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d        = REQ;
                    vec_d          = lowestVec;
                    ivselLatched_d = bus.ivsel;
                end
            end
            REQ: begin
                if (bus.int_taken) begin
                    state_d = ACK;
                end else if (!selectedLine || !bus.sreg_i) begin
                    state_d = IDLE;
                end
            end
            ACK: begin
                if (CALL_CYCLES == 0) begin
                    state_d = IDLE;
                end else begin
                    state_d = CALL;
                    count_d = CNT_W'(CALL_CYCLES);
                end
            end
            CALL: begin
                if (count_q <= CNT_W'(1)) begin
                    state_d = IDLE;
                    count_d = '0;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge cp2 or negedge ireset) begin
        if (!ireset) begin
            state_q        <= IDLE;
            vec_q          <= 6'd0;
            ivselLatched_q <= 1'b0;
            guard_q        <= 1'b0;
            count_q        <= '0;
        end else begin
            state_q        <= state_d;
            vec_q          <= vec_d;
            ivselLatched_q <= ivselLatched_d;
            guard_q        <= guard_d;
            count_q        <= count_d;
        end
    end

    assign bus.int_req     = (state_q == REQ);
    assign bus.irqack      = (state_q == ACK);
    assign bus.clr_i       = (state_q == ACK);
    assign bus.irqack_addr = (state_q == ACK) ? vec_q : 6'd0;
    assign bus.busy        = (state_q != IDLE);
    assign bus.int_vec_pc  = (ivselLatched_q ? BOOT_BASE : 16'h0000) + {9'd0, vec_q, 1'b0};
endmodule

// File: tb/tb_irq_vector_ctrl.sv
// Randomised scoreboard bench for irq_vector_ctrl: stimulus queues the expected acknowledge,
// a negedge monitor pops and compares each acknowledge the controller presents.
module tb_irq_vector_ctrl;
    localparam int          NUM_IRQ     = 44;
    localparam logic [15:0] BOOT_BASE   = 16'h3C00;
    localparam int          CALL_CYCLES = 3;

    typedef struct {
        logic [5:0]  addr;
        logic [15:0] pc;
    } expT;

    logic cp2;
    logic ireset;
    int   checks;
    int   failures;
    expT  expQ[$];
    logic prevAck;

    irq_vector_ctrl_if #(.NUM_IRQ(NUM_IRQ)) bus();

    irq_vector_ctrl #(
        .NUM_IRQ    (NUM_IRQ),
        .BOOT_BASE  (BOOT_BASE),
        .CALL_CYCLES(CALL_CYCLES)
    ) dut (
        .cp2   (cp2),
        .ireset(ireset),
        .bus   (bus.master)
    );

    initial begin
        cp2 = 1'b0;
        forever #5 cp2 = ~cp2;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge cp2);
        #1;
    endtask

    task automatic applyStimulus(input logic [NUM_IRQ-1:0] irq, input logic sreg,
                                 input logic ivsel, input logic boundary,
                                 input logic reti, input logic taken);
        bus.irq_in         = irq;
        bus.sreg_i         = sreg;
        bus.ivsel          = ivsel;
        bus.instr_boundary = boundary;
        bus.reti_exec      = reti;
        bus.int_taken      = taken;
    endtask

    // Reference: isolate the lowest set bit arithmetically, its position + 1 is the vector.
    function automatic expT modelResponse(input logic [NUM_IRQ-1:0] irq, input logic ivsel);
        expT         r;
        logic [63:0] wide;
        logic [63:0] low;
        wide   = 64'(irq);
        low    = wide & (~wide + 64'd1);
        r.addr = 6'($clog2(low) + 1);
        r.pc   = (ivsel ? BOOT_BASE : 16'h0000) + 16'(2 * r.addr);
        return r;
    endfunction

    function automatic logic [NUM_IRQ-1:0] randomIrq();
        logic [63:0] r;
        r = {$urandom, $urandom};
        if ($urandom_range(0, 1) == 1) r = r & {$urandom, $urandom} & {$urandom, $urandom};
        if (r[NUM_IRQ-1:0] == '0) r[$urandom_range(0, NUM_IRQ - 1)] = 1'b1;
        return r[NUM_IRQ-1:0];
    endfunction

    // Monitor: every acknowledge must match the oldest expectation and last a single cycle.
    always @(negedge cp2) begin
        if (ireset && (bus.irqack || bus.clr_i)) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_irqack actual=addr %0h required=no acknowledge",
                         bus.irqack_addr);
            end else begin
                expT e;
                e = expQ.pop_front();
                checkOutput("irqack_addr", 32'(bus.irqack_addr), 32'(e.addr));
                checkOutput("ack_vec_pc", 32'(bus.int_vec_pc), 32'(e.pc));
                checkOutput("irqack", 32'(bus.irqack), 32'd1);
                checkOutput("clr_i", 32'(bus.clr_i), 32'd1);
                checkOutput("irqack_single", 32'(prevAck), 32'd0);
            end
        end else if (ireset) begin
            checkOutput("irqack_addr_idle", 32'(bus.irqack_addr), 32'd0);
        end
        prevAck = bus.irqack;
    end

    // Grant at a boundary, optionally wait in REQ, take it, then measure the busy window.
    task automatic serviceTransaction(input logic [NUM_IRQ-1:0] irq, input logic ivsel,
                                      input logic dropAtTake);
        expT e;
        int  n;
        e = modelResponse(irq, ivsel);
        expQ.push_back(e);
        applyStimulus(irq, 1'b1, ivsel, 1'b1, 1'b0, 1'b0);
        tick();
        bus.instr_boundary = 1'b0;
        checkOutput("int_req_grant", 32'(bus.int_req), 32'd1);
        checkOutput("int_vec_pc", 32'(bus.int_vec_pc), 32'(e.pc));
        bus.ivsel = 1'($urandom_range(0, 1));
        repeat ($urandom_range(0, 3)) begin
            tick();
            checkOutput("int_req_hold", 32'(bus.int_req), 32'd1);
        end
        bus.int_taken = 1'b1;
        if (dropAtTake) bus.irq_in = '0;
        tick();
        bus.int_taken = 1'b0;
        checkOutput("int_req_after_take", 32'(bus.int_req), 32'd0);
        bus.irq_in = randomIrq();
        n = 0;
        while (bus.busy && n < 20) begin
            n++;
            tick();
            bus.irq_in = randomIrq();
        end
        checkOutput("busy_cycles", 32'(n), 32'(1 + CALL_CYCLES));
        checkOutput("vec_pc_held", 32'(bus.int_vec_pc), 32'(e.pc));
    endtask

    task automatic abortCase(input logic [NUM_IRQ-1:0] irq, input logic dropSreg);
        expT e;
        e = modelResponse(irq, 1'b0);
        applyStimulus(irq, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        bus.instr_boundary = 1'b0;
        checkOutput("abort_int_req_grant", 32'(bus.int_req), 32'd1);
        if (dropSreg) bus.sreg_i = 1'b0;
        else          bus.irq_in = irq & ~(NUM_IRQ'(1) << (e.addr - 6'd1));
        tick();
        checkOutput("abort_int_req", 32'(bus.int_req), 32'd0);
        checkOutput("abort_busy", 32'(bus.busy), 32'd0);
        bus.sreg_i = 1'b1;
    endtask

    initial begin
        logic sawReq;
        logic [NUM_IRQ-1:0] irq;
        checks   = 0;
        failures = 0;
        prevAck  = 1'b0;
        ireset   = 1'b0;
        applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        checkOutput("reset_int_req", 32'(bus.int_req), 32'd0);
        checkOutput("reset_irqack", 32'(bus.irqack), 32'd0);
        checkOutput("reset_irqack_addr", 32'(bus.irqack_addr), 32'd0);
        checkOutput("reset_clr_i", 32'(bus.clr_i), 32'd0);
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_vec_pc", 32'(bus.int_vec_pc), 32'd0);
        ireset = 1'b1;
        tick();

        irq = '0;
        irq[0] = 1'b1;
        irq[4] = 1'b1;
        serviceTransaction(irq, 1'b0, 1'b0);
        irq = '0;
        irq[26] = 1'b1;
        serviceTransaction(irq, 1'b1, 1'b0);

        abortCase(randomIrq(), 1'b0);
        abortCase(randomIrq(), 1'b1);
        serviceTransaction(randomIrq(), 1'b0, 1'b1);

        // RETI then boundary: that boundary is skipped, the next one grants.
        irq = '0;
        irq[9] = 1'b1;
        applyStimulus(irq, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(irq, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        bus.instr_boundary = 1'b0;
        checkOutput("reti_first_boundary", 32'(bus.int_req), 32'd0);
        serviceTransaction(irq, 1'b0, 1'b0);

        applyStimulus(irq, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        bus.reti_exec = 1'b0;
        checkOutput("reti_coincident", 32'(bus.int_req), 32'd0);
        tick();
        bus.instr_boundary = 1'b0;
        checkOutput("reti_coincident_next", 32'(bus.int_req), 32'd0);
        serviceTransaction(irq, 1'b1, 1'b0);

        // Asynchronous reset while in ACK.
        irq = randomIrq();
        applyStimulus(irq, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        bus.instr_boundary = 1'b0;
        checkOutput("pre_reset_int_req", 32'(bus.int_req), 32'd1);
        bus.int_taken = 1'b1;
        tick();
        bus.int_taken = 1'b0;
        checkOutput("pre_reset_irqack", 32'(bus.irqack), 32'd1);
        ireset = 1'b0;
        #1;
        checkOutput("mid_reset_irqack", 32'(bus.irqack), 32'd0);
        checkOutput("mid_reset_clr_i", 32'(bus.clr_i), 32'd0);
        checkOutput("mid_reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("mid_reset_vec_pc", 32'(bus.int_vec_pc), 32'd0);
        tick();
        ireset = 1'b1;
        serviceTransaction(randomIrq(), 1'b0, 1'b0);

        // Interrupts globally disabled: nothing may be requested.
        sawReq = 1'b0;
        applyStimulus('1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (100) begin
            bus.instr_boundary = 1'($urandom_range(0, 1));
            tick();
            sawReq = sawReq | bus.int_req;
        end
        checkOutput("sreg_off_no_req", 32'(sawReq), 32'd0);
        applyStimulus('0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        for (int k = 0; k < 30; k++) begin
            case ($urandom_range(0, 3))
                0, 1: serviceTransaction(randomIrq(), 1'($urandom_range(0, 1)), 1'b0);
                2:    abortCase(randomIrq(), 1'($urandom_range(0, 1)));
                default: begin
                    applyStimulus('0, 1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
                    tick();
                    bus.instr_boundary = 1'b0;
                    checkOutput("no_irq_no_req", 32'(bus.int_req), 32'd0);
                end
            endcase
        end

        applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
